// File: rtl/mips_bus_arbiter_pkg.sv
// Shared types and constants for the two-master MIPS bus arbiter.
package mips_bus_pkg;

    // Arbiter FSM: pick a master, drive the slave, hand the result back.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    // Master index: M0 = instruction fetch, M1 = load/store data.
    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_t;

    // Read data handed to a master whose access was aborted by the watchdog.
    localparam logic [31:0] ABORT_DATA_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/mips_bus_rr_arb.sv
// Combinational 2-way round-robin picker: the master not granted last wins a tie.
module mips_bus_rr_arb
    import mips_bus_pkg::*;
(
    input  logic [1:0] i_req,
    input  master_t    i_last_grant,
    output logic       o_grant_valid,
    output master_t    o_grant_idx
);

    // Lone requester wins outright; on a tie, grant whoever was not served last.
    always_comb begin
        o_grant_valid = |i_req;
        o_grant_idx   = M0;
        if (i_req == 2'b11)
            o_grant_idx = (i_last_grant == M0) ? M1 : M0;
        else if (i_req[1])
            o_grant_idx = M1;
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Shares one Avalon-style memory bus between instruction fetch (M0) and
// load/store (M1). One transaction in flight at a time, round-robin grant,
// and a watchdog that aborts slave accesses stalled for TIMEOUT cycles.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                TIMEOUT    = 1024,
    parameter logic [DATA_W-1:0] ABORT_DATA = DATA_W'(ABORT_DATA_DEFAULT)
) (
    input  logic                clk,
    input  logic                reset,
    // master 0: instruction fetch
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_waitrequest,
    // master 1: load/store
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_waitrequest,
    // memory side
    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    output logic [DATA_W/8-1:0] byteenable,
    input  logic [DATA_W-1:0]   readdata,
    input  logic                waitrequest,
    output logic                timeout_err
);

    // A zero TIMEOUT disables the watchdog; keep the counter at least one bit wide.
    localparam int                CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    state_t              r_state;
    master_t             r_grant;
    master_t             r_last_grant;
    logic                r_is_read;
    logic                r_abort;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_address;
    logic                r_read;
    logic                r_write;
    logic [DATA_W-1:0]   r_writedata;
    logic [DATA_W/8-1:0] r_byteenable;
    logic                r_m0_wait;
    logic                r_m1_wait;
    logic                r_timeout_err;

    logic                w_grant_valid;
    master_t             w_grant_idx;
    logic                w_sel_m1;
    logic                w_sel_wr;
    logic                w_done_rd;
    logic [DATA_W-1:0]   w_rdata;

    mips_bus_rr_arb u_rr_arb (
        .i_req         ({m1_read | m1_write, m0_read | m0_write}),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    // Winner's request; read+write together is treated as a write.
    assign w_sel_m1 = (w_grant_idx == M1);
    assign w_sel_wr = w_sel_m1 ? m1_write : m0_write;

    // Memory readdata arrives in the COMPLETE cycle, so it is steered straight
    // through to the granted master rather than registered.
    assign w_done_rd   = (r_state == COMPLETE) && r_is_read;
    assign w_rdata     = r_abort ? ABORT_DATA : readdata;
    assign m0_readdata = (w_done_rd && r_grant == M0) ? w_rdata : '0;
    assign m1_readdata = (w_done_rd && r_grant == M1) ? w_rdata : '0;

    assign m0_waitrequest = r_m0_wait;
    assign m1_waitrequest = r_m1_wait;
    assign address        = r_address;
    assign read           = r_read;
    assign write          = r_write;
    assign writedata      = r_writedata;
    assign byteenable     = r_byteenable;
    assign timeout_err    = r_timeout_err;

    // Arbitration FSM with registered slave strobes and master waitrequests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_grant       <= M0;
            r_last_grant  <= M1;
            r_is_read     <= 1'b0;
            r_abort       <= 1'b0;
            r_cnt         <= '0;
            r_address     <= '0;
            r_read        <= 1'b0;
            r_write       <= 1'b0;
            r_writedata   <= '0;
            r_byteenable  <= '0;
            r_m0_wait     <= 1'b1;
            r_m1_wait     <= 1'b1;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_grant      <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                        r_address    <= w_sel_m1 ? m1_address    : m0_address;
                        r_writedata  <= w_sel_m1 ? m1_writedata  : m0_writedata;
                        r_byteenable <= w_sel_m1 ? m1_byteenable : m0_byteenable;
                        r_write      <= w_sel_wr;
                        r_read       <= ~w_sel_wr;
                        r_is_read    <= ~w_sel_wr;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!waitrequest) begin
                        // accepted: result comes back next cycle
                        r_read    <= 1'b0;
                        r_write   <= 1'b0;
                        r_m0_wait <= (r_grant != M0);
                        r_m1_wait <= (r_grant != M1);
                        r_state   <= COMPLETE;
                    end else if (TIMEOUT != 0 && r_cnt == CNT_LAST) begin
                        // this is the TIMEOUT-th stalled cycle: give up on the slave
                        r_cnt         <= r_cnt + 1'b1;
                        r_read        <= 1'b0;
                        r_write       <= 1'b0;
                        r_abort       <= 1'b1;
                        r_timeout_err <= 1'b1;
                        r_m0_wait     <= (r_grant != M0);
                        r_m1_wait     <= (r_grant != M1);
                        r_state       <= COMPLETE;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                COMPLETE: begin
                    r_m0_wait <= 1'b1;
                    r_m1_wait <= 1'b1;
                    r_cnt     <= '0;
                    r_abort   <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_read  <= 1'b0;
                    r_write <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter with a hand-driven memory (TIMEOUT=8).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_mips_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] m0_address = '0, m1_address = '0;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_writedata = '0, m1_writedata = '0;
    logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] address, writedata;
    logic        read, write;
    logic [3:0]  byteenable;
    logic [31:0] readdata = '0;
    logic        waitrequest = 1'b0;
    logic        timeout_err;

    int checks = 0;
    int failures = 0;

    mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .ABORT_DATA(32'hFFFF_FFFF)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .readdata(readdata), .waitrequest(waitrequest),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        // ---------------- reset values ----------------
        #2 reset = 1'b1;
        smp();
        chk("rst_m0_wait", m0_waitrequest, 1);
        chk("rst_m1_wait", m1_waitrequest, 1);
        chk("rst_read", read, 0);
        chk("rst_write", write, 0);
        chk("rst_addr", address, 0);
        chk("rst_be", byteenable, 0);
        chk("rst_m0_rdata", m0_readdata, 0);
        chk("rst_tmo", timeout_err, 0);
        cyc(); reset = 1'b0;

        // ---------------- tie right after reset: M0 then M1 ----------------
        cyc();                                   // cycle 0
        m0_read = 1; m0_address = 32'h0000_0100;
        m1_read = 1; m1_address = 32'h0000_0200;
        smp(); chk("tie_c0_read", read, 0);
        cyc(); smp();                            // cycle 1
        chk("tie_c1_addr", address, 32'h0000_0100);
        chk("tie_c1_read", read, 1);
        cyc(); readdata = 32'hAAAA_0000; smp();  // cycle 2
        chk("tie_c2_m0_wait", m0_waitrequest, 0);
        chk("tie_c2_m1_wait", m1_waitrequest, 1);
        chk("tie_c2_m0_rdata", m0_readdata, 32'hAAAA_0000);
        chk("tie_c2_m1_rdata", m1_readdata, 0);
        cyc(); m0_read = 0; readdata = 0; smp(); // cycle 3
        chk("tie_c3_m1_wait", m1_waitrequest, 1);
        chk("tie_c3_read", read, 0);
        cyc(); smp();                            // cycle 4
        chk("tie_c4_addr", address, 32'h0000_0200);
        chk("tie_c4_read", read, 1);
        chk("tie_c4_m1_wait", m1_waitrequest, 1);
        cyc(); readdata = 32'hBBBB_1111; smp();  // cycle 5
        chk("tie_c5_m1_wait", m1_waitrequest, 0);
        chk("tie_c5_m1_rdata", m1_readdata, 32'hBBBB_1111);
        chk("tie_c5_m0_wait", m0_waitrequest, 1);
        cyc(); m1_read = 0; readdata = 0; smp(); // cycle 6, idle
        chk("tie_c6_m1_rdata", m1_readdata, 0);

        // ---------------- continuous requests alternate ----------------
        for (int t = 0; t < 6; t++) begin
            cyc();                               // IDLE: arbitrate
            if (t == 0) begin
                m0_read = 1; m0_address = 32'h0000_1000;
                m1_read = 1; m1_address = 32'h0000_2000;
            end
            cyc(); smp();                        // ISSUE
            chk($sformatf("rr%0d_addr", t), address, (t % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
            cyc(); smp();                        // COMPLETE
            chk($sformatf("rr%0d_m0_wait", t), m0_waitrequest, (t % 2 == 0) ? 0 : 1);
            chk($sformatf("rr%0d_m1_wait", t), m1_waitrequest, (t % 2 == 0) ? 1 : 0);
        end
        cyc(); m0_read = 0; m1_read = 0;

        // ---------------- M1 write with 5 wait cycles ----------------
        cyc();                                   // cycle 0
        m1_write = 1; m1_address = 32'h0000_3000;
        m1_writedata = 32'h0000_0014; m1_byteenable = 4'b0011;
        waitrequest = 1;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            waitrequest = (i < 6);
            smp();
            chk($sformatf("wr_c%0d_write", i), write, 1);
            chk($sformatf("wr_c%0d_addr", i), address, 32'h0000_3000);
            chk($sformatf("wr_c%0d_data", i), writedata, 32'h0000_0014);
            chk($sformatf("wr_c%0d_be", i), byteenable, 4'b0011);
            chk($sformatf("wr_c%0d_m1_wait", i), m1_waitrequest, 1);
        end
        cyc(); smp();                            // cycle 7: COMPLETE
        chk("wr_c7_write", write, 0);
        chk("wr_c7_m1_wait", m1_waitrequest, 0);
        chk("wr_c7_m1_rdata", m1_readdata, 0);
        chk("wr_c7_tmo", timeout_err, 0);
        cyc(); m1_write = 0; smp();
        chk("wr_c8_m1_wait", m1_waitrequest, 1);

        // ---------------- watchdog on a stalled M1 read ----------------
        cyc();                                   // cycle 0
        m1_read = 1; m1_address = 32'h0000_4000;
        waitrequest = 1; readdata = 32'h1234_5678;
        for (int i = 1; i <= 8; i++) begin
            cyc(); smp();
            chk($sformatf("to_c%0d_read", i), read, 1);
            chk($sformatf("to_c%0d_m1_wait", i), m1_waitrequest, 1);
        end
        cyc(); smp();                            // cycle 9: aborted completion
        chk("to_c9_read", read, 0);
        chk("to_c9_m1_wait", m1_waitrequest, 0);
        chk("to_c9_m1_rdata", m1_readdata, 32'hFFFF_FFFF);
        chk("to_c9_tmo", timeout_err, 1);
        cyc(); m1_read = 0; waitrequest = 0; readdata = 0; smp();
        chk("to_c10_m1_wait", m1_waitrequest, 1);
        chk("to_c10_m1_rdata", m1_readdata, 0);
        chk("to_c10_tmo_sticky", timeout_err, 1);
        cyc(); smp();
        chk("to_c11_tmo_sticky", timeout_err, 1);

        // ---------------- reset during ISSUE ----------------
        cyc();                                   // cycle 0
        m0_read = 1; m0_address = 32'h0000_5000; waitrequest = 1;
        cyc(); smp();                            // cycle 1
        chk("ri_c1_read", read, 1);
        cyc(); reset = 1; #1;                    // mid cycle 2
        chk("ri_read", read, 0);
        chk("ri_write", write, 0);
        chk("ri_m0_wait", m0_waitrequest, 1);
        chk("ri_m1_wait", m1_waitrequest, 1);
        chk("ri_tmo", timeout_err, 0);
        cyc(); reset = 0; m0_read = 0; waitrequest = 0;

        // ---------------- zero-wait M0 fetch after reset release ----------------
        cyc();                                   // cycle 0
        m0_read = 1; m0_address = 32'hBFC0_0000;
        smp();
        chk("f_c0_read", read, 0);
        chk("f_c0_m0_wait", m0_waitrequest, 1);
        cyc(); smp();                            // cycle 1
        chk("f_c1_read", read, 1);
        chk("f_c1_addr", address, 32'hBFC0_0000);
        chk("f_c1_m0_wait", m0_waitrequest, 1);
        cyc(); readdata = 32'h2402_0014; smp();  // cycle 2
        chk("f_c2_read", read, 0);
        chk("f_c2_m0_wait", m0_waitrequest, 0);
        chk("f_c2_m0_rdata", m0_readdata, 32'h2402_0014);
        chk("f_c2_m1_wait", m1_waitrequest, 1);
        cyc(); m0_read = 0; readdata = 0; smp(); // cycle 3
        chk("f_c3_m0_wait", m0_waitrequest, 1);
        chk("f_c3_m0_rdata", m0_readdata, 0);
        chk("f_c3_read", read, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
Shares the single Avalon-style memory bus of mips_cpu_bus between two internal masters: instruction fetch (M0) and load/store data (M1). It arbitrates round-robin, issues one transaction at a time to the memory, and holds each master in waitrequest until that master's transaction completes. A watchdog aborts slave accesses that stall too long.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; byteenable width is DATA_W/8
TIMEOUT, 1024, max cycles slave waitrequest may stay high in ISSUE; 0 disables watchdog
ABORT_DATA, 32'hFFFFFFFF, readdata returned to master on timeout

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
m0_address / m1_address  in  ADDR_W  master byte address
m0_read / m1_read  in  1  read request
m0_write / m1_write  in  1  write request
m0_writedata / m1_writedata  in  DATA_W  write data
m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes
m0_readdata / m1_readdata  out  DATA_W  read data, valid when that master's waitrequest is low
m0_waitrequest / m1_waitrequest  out  1  high = stall; low for exactly one cycle at completion
address  out  ADDR_W  to memory
read  out  1  to memory
write  out  1  to memory
writedata  out  DATA_W  to memory
byteenable  out  DATA_W/8  to memory
readdata  in  DATA_W  from memory, valid the cycle after acceptance
waitrequest  in  1  from memory; the access is accepted in the cycle read or write is high and waitrequest is low
timeout_err  out  1  sticky flag, set on any watchdog abort

Behaviour:
- Reset (async, immediate): state=IDLE; address, writedata, byteenable = 0; read, write = 0; m*_readdata = 0; m*_waitrequest = 1; timeout_err = 0; last_grant = M1, so M0 wins the first tie.
- A master requests by holding read or write high, with stable address, data and byteenable, until its waitrequest goes low. If read and write are both high, the request is treated as a write.
- FSM states: IDLE, ISSUE, COMPLETE.
- IDLE: if any request is present, pick the winner. A single requester wins outright. If both request, the master other than last_grant wins. Latch the winner's address, writedata, byteenable and read/write into slave output registers, update last_grant, and go to ISSUE. If there is no request, stay in IDLE with strobes low.
- ISSUE: drive the latched strobe. If waitrequest is low, the access is accepted and the state goes to COMPLETE; strobes go low in the COMPLETE cycle. Otherwise stay in ISSUE and increment the wait counter.
- Watchdog: if TIMEOUT is nonzero and the wait counter reaches TIMEOUT, drop the strobes, set timeout_err, set abort=1, and go to COMPLETE.
- COMPLETE: the granted master sees waitrequest=0 for this one cycle. For a read, its readdata is the memory readdata (or ABORT_DATA if aborted); for a write, readdata is don't-care and driven 0. The ungranted master's waitrequest stays 1. Next state is always IDLE; the wait counter and abort are cleared.
- m*_readdata is 0 in every cycle where that master's waitrequest is 1.
- Latency with a zero-wait memory: request seen in cycle 0, strobe in cycle 1, completion in cycle 2, next arbitration in cycle 3. Minimum spacing per transaction is 3 cycles.
- A master that drops its request mid-transaction has no effect: the latched access still completes.
- Reset asserted mid-ISSUE drops the strobes asynchronously. The memory must tolerate the abandoned access.
- Wait counter width is clog2(TIMEOUT+1). It saturates and never wraps.

Decomposition:
- Package mips_bus_pkg: state enum (IDLE, ISSUE, COMPLETE), master-index typedef (M0=0, M1=1), ABORT_DATA default constant.
- Sub-module mips_bus_rr_arb: a combinational 2-way round-robin picker. Inputs: req[1:0] and last_grant. Outputs: grant_valid and grant_idx.

Test Plan:
- M0 reads 32'hBFC00000 with zero-wait memory returning 32'h24020014 -> m0_waitrequest low in cycle 2 only, m0_readdata=32'h24020014, read high in cycle 1 only.
- M0 and M1 request together right after reset -> M0 is served first; M1 is issued in cycle 4 and completes in cycle 5; m1_waitrequest stays high through cycle 4.
- Both masters hold requests continuously for 6 transactions -> grants alternate M0, M1, M0, M1, M0, M1.
- M1 writes 32'h00000014 with byteenable 4'b0011 while memory holds waitrequest for 5 cycles -> write stays high with stable address and data for 6 cycles; m1_waitrequest is low one cycle after acceptance.
- TIMEOUT=8, memory holds waitrequest forever on an M1 read -> strobe drops after 8 wait cycles; m1_readdata=32'hFFFFFFFF for one cycle; timeout_err=1 and remains set.
- Assert reset during ISSUE -> read/write go low in the same cycle, both m*_waitrequest=1, and the first request after release is served normally.
